axi_stream_wr_dma: RTL and testbench
====================================

// Module: axi_stream_wr_dma
// PURPOSE
//  AXI-Stream to AXI4 write master; the upstream stage that fills axi_ram from a stream source.
//  Takes a (start address, beat count) command and packs stream beats into INCR bursts on AW/W.
//  Collects B responses and reports done/error per command.
//  One burst in flight at a time; bursts never cross a 4 KiB boundary.
// PARAMETERS
//  DATA_WIDTH     32  AXI/stream data width in bits
//  ADDR_WIDTH     16  AXI address width; must be >= 12
//  STRB_WIDTH     DATA_WIDTH/8  byte lanes; must be a power of two
//  ID_WIDTH       8   AXI ID width
//  AXI_ID         0   constant value driven on m_axi_awid
//  MAX_BURST_LEN  16  max beats per burst, 1..256
//  LEN_WIDTH      20  width of cmd_len
// PORTS
//  clk            in   1           clock
//  rst            in   1           reset: synchronous, active-high
//  cmd_addr       in   ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits are ignored (forced 0)
//  cmd_len        in   LEN_WIDTH   number of beats to write
//  cmd_valid/cmd_ready  in/out  1  command handshake
//  busy           out  1           high from command accept until done
//  status_done    out  1           one-cycle pulse at end of command
//  status_error   out  1           valid with status_done: any bresp != OKAY during the command
//  s_axis_tdata   in   DATA_WIDTH  stream data
//  s_axis_tvalid/s_axis_tready  in/out  1  stream handshake
//  m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3  AW channel
//  m_axi_awvalid/m_axi_awready  out/in  1  AW handshake
//  m_axi_wdata/wstrb/wlast  out  DATA_WIDTH/STRB_WIDTH/1  W channel
//  m_axi_wvalid/m_axi_wready  out/in  1  W handshake
//  m_axi_bid/bresp  in  ID_WIDTH/2  B channel (bid is ignored)
//  m_axi_bvalid/m_axi_bready  in/out  1  B handshake
// BEHAVIOUR
//  Constants: awsize=log2(STRB_WIDTH), awburst=2'b01, awlock=0, awcache=4'b0011, awprot=0, awid=AXI_ID, wstrb=all ones.
//  States:
//   IDLE: cmd_ready=1.
//    cmd accept with len==0 -> status_done pulse next cycle, no AXI traffic; stay in IDLE.
//    cmd accept with len>0  -> ADDR. Latch addr and remaining=len, clear error.
//   ADDR: awvalid=1, awaddr=addr.
//    awlen+1 = min(remaining, MAX_BURST_LEN, (4096 - addr[11:0]) >> log2(STRB_WIDTH)).
//    awvalid/awaddr/awlen are held stable until awready -> DATA. Load beat_cnt=awlen.
//   DATA: wvalid=s_axis_tvalid, s_axis_tready=m_axi_wready, wdata=tdata; combinational pass-through, no buffering.
//    wlast = (beat_cnt==0).
//    On each W handshake beat_cnt decrements; on the wlast handshake: addr += (awlen+1)*STRB_WIDTH, remaining -= awlen+1 -> RESP.
//   RESP: bready=1. On bvalid: error |= (bresp!=0).
//    remaining==0 -> IDLE with status_done=1, status_error=error for that one cycle.
//    else -> ADDR.
//  Outside DATA: s_axis_tready=0, wvalid=0. Outside RESP: bready=0.
//  Latency: cmd accept in cycle N -> awvalid in cycle N+1. Next burst awvalid one cycle after the B handshake.
//  The next burst's awlen is computed from the registered addr/remaining; no combinational path from B to AW.
//  A stream stall or wready low simply holds the beat; beats are never dropped, duplicated or reordered.
//  An error does not abort the command: all remaining bursts are still issued.
//  Address arithmetic wraps modulo 2**ADDR_WIDTH.
//  Reset: state=IDLE; cmd_ready=1; busy, status_done, status_error, awvalid, wvalid, bready, s_axis_tready=0.
//   Reset mid-burst abandons the transfer immediately; the AXI slave must be reset with it.
// TESTING  (DATA_WIDTH=32, MAX_BURST_LEN=16, bench slave = axi_ram)
//  1 addr 0x0100, len 4, data 1..4 -> one AW (0x0100, awlen 3), wlast on beat 4, done, error=0; RAM 0x0100..0x010C = 1..4.
//  2 addr 0x0000, len 40 -> AW 0x0000/len15, 0x0040/len15, 0x0080/len7; then one done pulse.
//  3 addr 0x0FF8, len 6 -> AW 0x0FF8/awlen 1, then 0x1000/awlen 3; no burst crosses 0x1000.
//  4 random tvalid gaps + random wready/awready stalls, len 100 -> RAM contents equal stream order, exactly 100 W beats.
//  5 inject bresp=2'b10 on burst 1 of 2 -> burst 2 still issued; done with error=1; next command reports error=0.
//  6 len 0 -> done pulse 1 cycle after accept, no awvalid; rst asserted mid-DATA -> next cycle all valids 0, cmd_ready 1.

Source files
------------

// File: rtl/axi_stream_wr_dma.sv
// AXI-Stream to AXI4 write master: turns (address, beat count) commands into
// 4 KiB-safe INCR bursts, one in flight at a time, and reports done/error.
module axi_stream_wr_dma #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH      = 8,
  parameter int unsigned AXI_ID        = 0,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned LEN_WIDTH     = 20
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  status_done,
  output logic                  status_error,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,

  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int unsigned SIZE  = $clog2(STRB_WIDTH);
  localparam int unsigned CNT_W = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [8:0]            burst_len_q, burst_len_d;
  logic                  error_q, error_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  status_error_q, status_error_d;

  logic [12:0]           bytes_to_4k;
  logic [CNT_W-1:0]      bound_4k;
  logic [CNT_W-1:0]      burst_c;
  logic [7:0]            awlen_c;
  logic                  w_hs_c;
  logic                  err_v;
  logic                  unused_bid;

  assign unused_bid = ^m_axi_bid;

  // Burst size from registered address/remaining only: min(remaining, max, beats to 4 KiB)
  always_comb begin
    bytes_to_4k = 13'd4096 - {1'b0, addr_q[11:0]};
    bound_4k    = CNT_W'(bytes_to_4k >> SIZE);
    burst_c     = CNT_W'(remaining_q);
    if (CNT_W'(MAX_BURST_LEN) < burst_c) burst_c = CNT_W'(MAX_BURST_LEN);
    if (bound_4k < burst_c)              burst_c = bound_4k;
    awlen_c     = 8'(burst_c - CNT_W'(1));
  end

  assign w_hs_c = (state_q == S_DATA) && s_axis_tvalid && m_axi_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      beat_cnt_q     <= '0;
      burst_len_q    <= '0;
      error_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      status_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      beat_cnt_q     <= beat_cnt_d;
      burst_len_q    <= burst_len_d;
      error_q        <= error_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      status_error_q <= status_error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    remaining_d    = remaining_q;
    beat_cnt_d     = beat_cnt_q;
    burst_len_d    = burst_len_q;
    error_d        = error_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    status_error_d = 1'b0;
    err_v          = error_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_ADDR;
            addr_d      = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
            remaining_d = cmd_len;
            error_d     = 1'b0;
            busy_d      = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (m_axi_awready) begin
          state_d     = S_DATA;
          beat_cnt_d  = awlen_c;
          burst_len_d = 9'(burst_c);
        end
      end
      S_DATA: begin
        if (w_hs_c) begin
          if (beat_cnt_q == 8'd0) begin
            addr_d      = addr_q + (ADDR_WIDTH'(burst_len_q) << SIZE);
            remaining_d = remaining_q - LEN_WIDTH'(burst_len_q);
            state_d     = S_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      S_RESP: begin
        if (m_axi_bvalid) begin
          err_v   = error_q | (m_axi_bresp != 2'b00);
          error_d = err_v;
          if (remaining_q == '0) begin
            state_d        = S_IDLE;
            done_d         = 1'b1;
            status_error_d = err_v;
            busy_d         = 1'b0;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = busy_q;
  assign status_done   = done_q;
  assign status_error  = status_error_q;

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_c;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = (state_q == S_ADDR);

  // Stream beats pass straight through to W with no buffering
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state_q == S_DATA) && (beat_cnt_q == 8'd0);
  assign m_axi_wvalid  = (state_q == S_DATA) && s_axis_tvalid;
  assign s_axis_tready = (state_q == S_DATA) && m_axi_wready;
  assign m_axi_bready  = (state_q == S_RESP);

endmodule

// File: tb/tb_axi_stream_wr_dma.sv
// Bench for axi_stream_wr_dma: behavioural AXI write slave with RAM, stream
// source, table-driven burst-split vectors and hand-written corner sequences.
module tb_axi_stream_wr_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_addr;
  logic [19:0] cmd_len;
  logic        cmd_valid, cmd_ready, busy, status_done, status_error;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic [7:0]  m_axi_awid;
  logic [15:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [7:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;

  axi_stream_wr_dma dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .busy(busy), .status_done(status_done), .status_error(status_error),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- AXI write slave with RAM ----------------
  logic [31:0] mem [0:16383];
  int          aw_cnt = 0, w_beats = 0, wlast_err = 0, cross_err = 0, stable_err = 0;
  int          inject_burst = -1;
  bit          stall_en = 1'b0;
  bit          aw_pending = 1'b0;
  logic [15:0] pend_addr, cur_addr, wa;
  logic [7:0]  pend_len;
  int          cur_len, cur_beat, cur_idx;
  int          aw_addr_log[$];
  int          aw_len_log[$];

  assign m_axi_bid = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      m_axi_awready <= 1'b0;
      m_axi_wready  <= 1'b0;
      m_axi_bvalid  <= 1'b0;
      m_axi_bresp   <= 2'b00;
      aw_pending = 1'b0;
    end else begin
      if (m_axi_awvalid) begin
        if (aw_pending && (m_axi_awaddr != pend_addr || m_axi_awlen != pend_len)) stable_err++;
        if (m_axi_awready) begin
          aw_addr_log.push_back(int'(m_axi_awaddr));
          aw_len_log.push_back(int'(m_axi_awlen));
          if (int'(m_axi_awaddr[11:0]) + (int'(m_axi_awlen) + 1) * 4 > 4096) cross_err++;
          cur_addr = m_axi_awaddr;
          cur_len  = int'(m_axi_awlen);
          cur_beat = 0;
          cur_idx  = aw_cnt;
          aw_cnt++;
          aw_pending = 1'b0;
        end else begin
          aw_pending = 1'b1;
          pend_addr  = m_axi_awaddr;
          pend_len   = m_axi_awlen;
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        wa = cur_addr + 16'(cur_beat * 4);
        mem[wa[15:2]] = m_axi_wdata;
        w_beats++;
        if (m_axi_wlast != (cur_beat == cur_len)) wlast_err++;
        cur_beat++;
        if (m_axi_wlast) begin
          m_axi_bvalid <= 1'b1;
          m_axi_bresp  <= (cur_idx == inject_burst) ? 2'b10 : 2'b00;
        end
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      m_axi_awready <= stall_en ? ($urandom % 3 != 0) : 1'b1;
      m_axi_wready  <= stall_en ? ($urandom % 3 != 0) : 1'b1;
    end
  end

  // ---------------- stream source ----------------
  logic [31:0] sq[$];
  bit          gaps_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      s_axis_tvalid <= 1'b0;
      sq.delete();
    end else begin
      if (s_axis_tvalid && s_axis_tready) void'(sq.pop_front());
      if (!(s_axis_tvalid && !s_axis_tready)) begin
        if (sq.size() > 0 && (!gaps_en || ($urandom % 4 != 0))) begin
          s_axis_tvalid <= 1'b1;
          s_axis_tdata  <= sq[0];
        end else begin
          s_axis_tvalid <= 1'b0;
        end
      end
    end
  end

  // ---------------- command helper ----------------
  task automatic run_cmd(input logic [15:0] addr, input int len, input logic [31:0] base,
                         input int budget, output bit ok, output bit err);
    aw_addr_log.delete();
    aw_len_log.delete();
    for (int i = 0; i < len; i++) sq.push_back(base + 32'(i));
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_addr  = addr;
    cmd_len   = 20'(len);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    ok  = 1'b0;
    err = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (status_done) begin
        ok  = 1'b1;
        err = status_error;
        check("busy_at_done", 32'(busy), 32'd0);
        break;
      end
    end
    check("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic check_mem(input logic [15:0] addr, input int len, input logic [31:0] base);
    logic [15:0] a;
    for (int i = 0; i < len; i++) begin
      a = (addr & 16'hFFFC) + 16'(i * 4);
      check($sformatf("mem[%0h]", a), mem[a[15:2]], base + 32'(i));
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    int          len;
    int          n_aw;
    int          aw_addr [3];
    int          aw_len  [3];
  } vec_t;

  vec_t vecs [5];

  initial begin
    bit ok, err;
    int wb0, aw0, sum;

    vecs[0] = '{addr: 16'h0100, len: 4,  n_aw: 1, aw_addr: '{'h0100, 0, 0},           aw_len: '{3, 0, 0}};
    vecs[1] = '{addr: 16'h0000, len: 40, n_aw: 3, aw_addr: '{'h0000, 'h0040, 'h0080}, aw_len: '{15, 15, 7}};
    vecs[2] = '{addr: 16'h0FF8, len: 6,  n_aw: 2, aw_addr: '{'h0FF8, 'h1000, 0},      aw_len: '{1, 3, 0}};
    vecs[3] = '{addr: 16'h0203, len: 2,  n_aw: 1, aw_addr: '{'h0200, 0, 0},           aw_len: '{1, 0, 0}};
    vecs[4] = '{addr: 16'h1FD0, len: 20, n_aw: 2, aw_addr: '{'h1FD0, 'h2000, 0},      aw_len: '{11, 7, 0}};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    s_axis_tdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(status_done), 32'd0);
    check("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    check("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
    check("rst_bready", 32'(m_axi_bready), 32'd0);
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("awsize", 32'(m_axi_awsize), 32'd2);
    check("awburst", 32'(m_axi_awburst), 32'd1);
    check("awcache", 32'(m_axi_awcache), 32'd3);
    check("wstrb", 32'(m_axi_wstrb), 32'hF);

    // Burst splitting vectors
    for (int t = 0; t < 5; t++) begin
      wb0 = w_beats;
      run_cmd(vecs[t].addr, vecs[t].len, 32'hA000_0000 + 32'(t * 256), 2000, ok, err);
      check($sformatf("v%0d_error", t), 32'(err), 32'd0);
      check($sformatf("v%0d_n_aw", t), 32'(aw_addr_log.size()), 32'(vecs[t].n_aw));
      for (int b = 0; b < vecs[t].n_aw && b < aw_addr_log.size(); b++) begin
        check($sformatf("v%0d_awaddr%0d", t, b), 32'(aw_addr_log[b]), 32'(vecs[t].aw_addr[b]));
        check($sformatf("v%0d_awlen%0d", t, b), 32'(aw_len_log[b]), 32'(vecs[t].aw_len[b]));
      end
      check($sformatf("v%0d_w_beats", t), 32'(w_beats - wb0), 32'(vecs[t].len));
      check_mem(vecs[t].addr, vecs[t].len, 32'hA000_0000 + 32'(t * 256));
    end

    // Random stalls on stream, AW and W
    stall_en = 1'b1;
    gaps_en  = 1'b1;
    wb0 = w_beats;
    run_cmd(16'h5000, 100, 32'hB000_0000, 5000, ok, err);
    check("stall_error", 32'(err), 32'd0);
    check("stall_w_beats", 32'(w_beats - wb0), 32'd100);
    check("stall_n_aw", 32'(aw_addr_log.size()), 32'd7);
    sum = 0;
    foreach (aw_len_log[i]) sum += aw_len_log[i] + 1;
    check("stall_len_sum", 32'(sum), 32'd100);
    check("stall_stream_drained", 32'(sq.size()), 32'd0);
    check_mem(16'h5000, 100, 32'hB000_0000);
    stall_en = 1'b0;
    gaps_en  = 1'b0;
    repeat (2) @(negedge clk);

    // Error on first of two bursts; command completes, next command is clean
    inject_burst = aw_cnt;
    run_cmd(16'h6000, 32, 32'hC000_0000, 2000, ok, err);
    check("err_cmd_error", 32'(err), 32'd1);
    check("err_cmd_n_aw", 32'(aw_addr_log.size()), 32'd2);
    check_mem(16'h6000, 32, 32'hC000_0000);
    inject_burst = -1;
    run_cmd(16'h6100, 1, 32'hC100_0000, 2000, ok, err);
    check("after_err_error", 32'(err), 32'd0);

    // Zero-length command
    aw0 = aw_cnt;
    @(negedge clk);
    cmd_addr  = 16'h0400;
    cmd_len   = 20'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("len0_done", 32'(status_done), 32'd1);
    check("len0_error", 32'(status_error), 32'd0);
    check("len0_awvalid", 32'(m_axi_awvalid), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("len0_done_pulse", 32'(status_done), 32'd0);
    repeat (3) @(negedge clk);
    check("len0_no_aw", 32'(aw_cnt), 32'(aw0));

    // Reset in the middle of DATA
    for (int i = 0; i < 8; i++) sq.push_back(32'hD000_0000 + 32'(i));
    @(negedge clk);
    cmd_addr  = 16'h7000;
    cmd_len   = 20'd8;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (m_axi_wvalid) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_mid_reached_data", 32'(ok), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_awvalid", 32'(m_axi_awvalid), 32'd0);
    check("rst_mid_wvalid", 32'(m_axi_wvalid), 32'd0);
    check("rst_mid_bready", 32'(m_axi_bready), 32'd0);
    check("rst_mid_tready", 32'(s_axis_tready), 32'd0);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_cmd(16'h7100, 3, 32'hE000_0000, 2000, ok, err);
    check("recover_error", 32'(err), 32'd0);
    check("recover_n_aw", 32'(aw_addr_log.size()), 32'd1);
    check_mem(16'h7100, 3, 32'hE000_0000);

    check("wlast_errors", 32'(wlast_err), 32'd0);
    check("cross_4k_errors", 32'(cross_err), 32'd0);
    check("aw_stability_errors", 32'(stable_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
